// File: rtl/fila_circular.sv
// Circular-buffer FIFO with read/write pointers, occupancy counter, registered status flags.
// Define FILA_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise both read 0.
module fila_circular #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 8,
    parameter int ALMOST_FULL_TH = DEPTH - 2,
    parameter int LEN_W          = $clog2(DEPTH) + 1
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic              clear_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              empty_out,
    output logic              full_out,
    output logic              almost_full_out,
    output logic              overflow_out,
    output logic              underflow_out
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;
    logic [LEN_W-1:0]  len_next;

    // A dequeue is accepted only when non-empty; an enqueue on a full queue is
    // accepted only if a dequeue frees a slot in the same cycle. valid_out pulses
    // for exactly one cycle, the cycle after an accepted dequeue, with data_out.
    always_comb begin
        do_rd    = dequeue_in && !empty_out;
        do_wr    = enqueue_in && (!full_out || do_rd);
        len_next = len_out;
        if (clear_in)
            len_next = '0;
        else if (do_wr && !do_rd)
            len_next = len_out + LEN_W'(1);
        else if (do_rd && !do_wr)
            len_next = len_out - LEN_W'(1);
    end

    // Storage has no reset; pointers alone define which entries are live.
    always_ff @(posedge clk_10KHz) begin
        if (do_wr && !clear_in)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            len_out         <= '0;
            data_out        <= '0;
            valid_out       <= 1'b0;
            empty_out       <= 1'b1;
            full_out        <= 1'b0;
            almost_full_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (clear_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_rd) begin
                    data_out  <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    valid_out <= 1'b1;
                end
            end
            // Flags are derived from the next occupancy so they change together with len_out.
            len_out         <= len_next;
            empty_out       <= (len_next == '0);
            full_out        <= (len_next == LEN_W'(DEPTH));
            almost_full_out <= (len_next >= LEN_W'(ALMOST_FULL_TH));
        end
    end

`ifdef FILA_ERR_FLAGS_EN
    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else if (clear_in) begin
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            if (enqueue_in && full_out && !dequeue_in)
                overflow_out <= 1'b1;
            if (dequeue_in && empty_out)
                underflow_out <= 1'b1;
        end
    end
`else
    assign overflow_out  = 1'b0;
    assign underflow_out = 1'b0;
`endif

endmodule

// File: doc/fila_circular.md
Name: fila_circular

Overview:
Parametrised circular-buffer FIFO. Successor to the fixed 8x8 shift-register queue.
- Uses read/write pointers instead of shifting, so cost stays flat as depth grows.
- Supports enqueue and dequeue in the same cycle, synchronous flush, status flags and optional sticky error flags.
- Sits between the input capture logic and the display/consumer logic in the 10 kHz clock domain.

Parameters:
DATA_W, 8, width of each entry in bits
DEPTH, 8, number of entries; power of two, >= 2
ALMOST_FULL_TH, DEPTH-2, almost_full_out asserts when len_out >= this value; range 1..DEPTH
LEN_W, $clog2(DEPTH)+1, width of len_out; derived, not overridden

Ports:
clk_10KHz  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  DATA_W  entry to enqueue
enqueue_in  in  1  write request, sampled each rising edge
dequeue_in  in  1  read request, sampled each rising edge
clear_in  in  1  synchronous flush
data_out  out  DATA_W  last dequeued entry, registered
valid_out  out  1  one-cycle pulse: data_out updated this cycle
len_out  out  LEN_W  current occupancy, 0..DEPTH
empty_out  out  1  len_out == 0
full_out  out  1  len_out == DEPTH
almost_full_out  out  1  len_out >= ALMOST_FULL_TH
overflow_out  out  1  sticky: enqueue attempted while full (optional feature)
underflow_out  out  1  sticky: dequeue attempted while empty (optional feature)

Behaviour:
- Reset (reset == 0, asynchronous assert, synchronous release):
  - Read and write pointers = 0; len_out = 0.
  - data_out = 0; valid_out = 0; empty_out = 1; full_out = 0; almost_full_out = 0; overflow_out = 0; underflow_out = 0.
  - Storage contents are don't-care.
- Pointers: $clog2(DEPTH) bits wide; wrap DEPTH-1 -> 0 naturally. len_out is a separate counter.
- Effective operations each cycle:
  - do_wr = enqueue_in && (!full || do_rd)
  - do_rd = dequeue_in && !empty
- do_wr:
  - mem[wr_ptr] <= data_in; wr_ptr += 1.
- do_rd:
  - data_out <= mem[rd_ptr]; rd_ptr += 1; valid_out = 1 next cycle. Latency is one cycle from request to data_out.
- len_out update:
  - +1 on wr only; -1 on rd only; unchanged when both or neither.
- Simultaneous enqueue and dequeue:
  - Non-empty (including full): both operations execute; len_out unchanged.
  - Empty: enqueue only; dequeue ignored (no bypass). Counts as underflow.
- Full, enqueue only: write dropped; contents unchanged.
- Empty, dequeue only: no-op; data_out holds; valid_out = 0.
- clear_in:
  - Pointers and len_out return to 0 next edge; flags follow.
  - Overrides enqueue_in/dequeue_in that cycle.
  - data_out holds its value; valid_out = 0.
  - Sticky error flags also clear.
- Flags (empty_out, full_out, almost_full_out) are registered, consistent with len_out in the same cycle, and never glitch.
- data_out holds its value between reads.
- Reset mid-operation: immediate return to reset state; no partial writes are observable afterwards.

Optional Feature:
FILA_ERR_FLAGS_EN
- Defined:
  - overflow_out sets on a cycle with enqueue_in && full && !dequeue_in.
  - underflow_out sets on a cycle with dequeue_in && empty.
  - Both stay high until reset or clear_in.
- Undefined:
  - Both ports tied to 0 and no flag registers are synthesised.
  - All other behaviour is identical.

Test Plan:
1. Reset; enqueue 0x11, 0x22, 0x33 on consecutive cycles -> len_out 1,2,3; empty_out 0. Then dequeue x3 -> data_out 0x11, 0x22, 0x33 each one cycle after request; valid_out pulses; len_out 0; empty_out 1.
2. DEPTH=8: enqueue 0x00..0x07 -> full_out 1; almost_full_out from len 6. Enqueue 0xAA -> dropped; overflow_out 1 (with macro). Dequeue 8 -> 0x00..0x07 in order.
3. Wrap: enqueue 6, dequeue 6, enqueue 0x40..0x45 -> pointers wrap. Dequeue yields 0x40..0x45 in order; len_out returns to 0.
4. Full plus simultaneous enqueue 0x99 and dequeue -> oldest entry out; 0x99 stored; len_out stays 8; no overflow.
5. Empty plus simultaneous enqueue 0x5A and dequeue -> len_out 1; valid_out 0; underflow_out 1. Next dequeue -> data_out 0x5A.
6. len_out 5, then clear_in -> len_out 0, empty_out 1, error flags 0, data_out unchanged. Then pull reset low mid-burst -> all outputs at reset values immediately.
